// File: rtl/channel_wave_buffer_if.sv
// AXI-Stream beat carrier between the channel router lane and a wave buffer.
// The master drives data/valid/last and the slave returns ready.
interface channel_wave_buffer_if #(
  parameter int DATA_W = 256
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/channel_wave_buffer.sv
// Per-channel waveform capture/playback: stores one AXI-Stream frame and replays
// it to the DAC datapath once or in a loop, with a 3-cycle trigger-to-data latency.
module channel_wave_buffer #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  channel_wave_buffer_if.slave   s_axis,
  input  logic                   load_start,
  input  logic                   trigger,
  input  logic                   stop,
  input  logic                   repeat_en,
  output logic [DATA_W-1:0]      dac_tdata,
  output logic                   dac_tvalid,
  output logic [ADDR_W:0]        loaded_words,
  output logic                   overflow,
  output logic [1:0]             state_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_ARMED, S_RUN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LW_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic                rep_q, tready_q, tready_nxt;
  logic                beat, mem_we, rd_last, kill;
  logic                vld_p0, vld_p1;
  logic [DATA_W-1:0]   rd_data_p1;

  assign s_axis.tready = tready_q;
  assign beat    = s_axis.tvalid & tready_q;
  assign rd_last = ({1'b0, rd_ptr} == (loaded_words - LW_ONE));
  // A stop only aborts an active playback; load_start aborts unconditionally.
  assign kill    = load_start | (stop & (state == S_RUN));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_LOAD: begin
          if (beat && s_axis.tlast)       state_nxt = S_ARMED;
          else if (beat && wr_ptr == LAST_ADDR) state_nxt = S_DRAIN;
        end
        S_DRAIN: if (beat && s_axis.tlast) state_nxt = S_ARMED;
        S_ARMED: if (trigger)              state_nxt = S_RUN;
        S_RUN: begin
          if (stop)                        state_nxt = S_ARMED;
          else if (rd_last && !rep_q)      state_nxt = S_ARMED;
        end
        default:                           state_nxt = state;
      endcase
    end
  end

  always_comb begin
    mem_we     = beat & (state == S_LOAD) & ~load_start;
    vld_p0     = (state == S_RUN);
    tready_nxt = (state_nxt == S_LOAD) | (state_nxt == S_DRAIN);
    case (state)
      S_LOAD, S_DRAIN: state_o = 2'd1;
      S_ARMED:         state_o = 2'd2;
      S_RUN:           state_o = 2'd3;
      default:         state_o = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tready_q     <= 1'b0;
      wr_ptr       <= '0;
      loaded_words <= '0;
      overflow     <= 1'b0;
    end else begin
      tready_q <= tready_nxt;
      if (load_start) begin
        wr_ptr       <= '0;
        loaded_words <= '0;
        overflow     <= 1'b0;
      end else if (mem_we) begin
        wr_ptr <= wr_ptr + A_ONE;
        if (s_axis.tlast) begin
          loaded_words <= {1'b0, wr_ptr} + LW_ONE;
        end else if (wr_ptr == LAST_ADDR) begin
          loaded_words <= DEPTH_W;
          overflow     <= 1'b1;
        end
      end
    end
  end

  // Stage p0: read address issue while RUN; wraps seamlessly when looping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      rep_q  <= 1'b0;
    end else if (state == S_ARMED && trigger && !load_start) begin
      rd_ptr <= '0;
      rep_q  <= repeat_en;
    end else if (state == S_RUN && !kill) begin
      rd_ptr <= rd_last ? '0 : rd_ptr + A_ONE;
    end
  end

  // Stage p1: registered memory read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= s_axis.tdata;
    if (vld_p0) rd_data_p1 <= mem[rd_ptr];
  end

  // Stage p2: DAC output register, forced to zero whenever not valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1     <= 1'b0;
      dac_tvalid <= 1'b0;
      dac_tdata  <= '0;
    end else begin
      vld_p1 <= vld_p0 & ~kill;
      if (kill) begin
        dac_tvalid <= 1'b0;
        dac_tdata  <= '0;
      end else begin
        dac_tvalid <= vld_p1;
        dac_tdata  <= vld_p1 ? rd_data_p1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_channel_wave_buffer.sv
// Scoreboard bench for channel_wave_buffer at DEPTH=8: random frames, single-shot,
// looping, stop, overflow, load_start abort and asynchronous reset.
module tb_channel_wave_buffer;
  localparam int DATA_W = 256;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              load_start = 1'b0, trigger = 1'b0, stop = 1'b0, repeat_en = 1'b0;
  logic [DATA_W-1:0] dac_tdata;
  logic              dac_tvalid;
  logic [ADDR_W:0]   loaded_words;
  logic              overflow;
  logic [1:0]        state_o;

  channel_wave_buffer_if #(.DATA_W(DATA_W)) s_if ();

  channel_wave_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .s_axis(s_if),
    .load_start(load_start), .trigger(trigger), .stop(stop), .repeat_en(repeat_en),
    .dac_tdata(dac_tdata), .dac_tvalid(dac_tvalid), .loaded_words(loaded_words),
    .overflow(overflow), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] frame[$];
  logic [DATA_W-1:0] ref_mem[DEPTH];
  logic [DATA_W-1:0] mon_exp;
  int ref_loaded = 0;
  bit ref_ovf = 1'b0;

  task automatic chk_w(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid DAC word must be the next scoreboard entry.
  always @(negedge clk) begin
    if (rstn) begin
      if (dac_tvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dac_unexpected: got %0h expected no word", dac_tdata);
        end else begin
          mon_exp = exp_q.pop_front();
          chk_w("dac_word", dac_tdata, mon_exp);
        end
      end else begin
        chk_w("dac_idle_zero", dac_tdata, '0);
      end
    end
  end

  task automatic do_load_start;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk_v("load_tready", 32'(s_if.tready), 1);
    chk_v("load_state", 32'(state_o), 1);
    chk_v("load_cleared", 32'(loaded_words), 0);
    chk_v("load_ovf_clr", 32'(overflow), 0);
  endtask

  // Sends a frame of len beats with the given valid duty (%), then updates the model.
  task automatic send_frame(input int len, input int duty, output int tready_cycles);
    frame.delete();
    tready_cycles = 0;
    for (int i = 0; i < len; i++) begin
      logic [DATA_W-1:0] w;
      bit acc;
      int guard;
      for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom();
      frame.push_back(w);
      while ($urandom_range(0, 99) >= duty) begin
        s_if.tvalid = 1'b0;
        tick();
      end
      s_if.tdata  = w;
      s_if.tvalid = 1'b1;
      s_if.tlast  = (i == len - 1);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 20) begin
        acc = s_if.tready;
        if (acc) tready_cycles++;
        tick();
        guard++;
      end
      chk_v("beat_accept", 32'(acc), 1);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    ref_loaded = (len > DEPTH) ? DEPTH : len;
    ref_ovf    = (len > DEPTH);
    for (int i = 0; i < ref_loaded; i++) ref_mem[i] = frame[i];
  endtask

  task automatic check_armed;
    chk_v("armed_state", 32'(state_o), 2);
    chk_v("armed_loaded", 32'(loaded_words), ref_loaded);
    chk_v("armed_ovf", 32'(overflow), 32'(ref_ovf));
    chk_v("armed_tready", 32'(s_if.tready), 0);
  endtask

  task automatic play_single;
    for (int i = 0; i < ref_loaded; i++) exp_q.push_back(ref_mem[i]);
    repeat_en = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int t = 1; t <= ref_loaded + 5; t++) begin
      if (t == 1) chk_v("run_state", 32'(state_o), 3);
      chk_v("single_vld", 32'(dac_tvalid), 32'(t >= 3 && t < 3 + ref_loaded));
      tick();
    end
    chk_v("single_end_state", 32'(state_o), 2);
    chk_v("single_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic pulse_reset;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    chk_v("rst_state", 32'(state_o), 0);
    chk_v("rst_tready", 32'(s_if.tready), 0);
    chk_v("rst_dac_vld", 32'(dac_tvalid), 0);
    chk_w("rst_dac_data", dac_tdata, '0);
    chk_v("rst_loaded", 32'(loaded_words), 0);
    chk_v("rst_ovf", 32'(overflow), 0);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int trc;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    tick();
    tick();
    pulse_reset();
    tick();

    // 5-beat frame, back-to-back valid, single-shot playback.
    do_load_start();
    send_frame(5, 100, trc);
    chk_v("tready_cycles5", 32'(trc), 5);
    check_armed();
    play_single();

    // Same frame looping: 12 words D0..D4,D0..D4,D0,D1 then stop.
    for (int i = 0; i < 12; i++) exp_q.push_back(ref_mem[i % ref_loaded]);
    repeat_en = 1'b1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat_en = 1'b0;
    for (int t = 1; t <= 14; t++) begin
      chk_v("rep_vld", 32'(dac_tvalid), 32'(t >= 3));
      if (t < 14) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_v("stop_vld", 32'(dac_tvalid), 0);
    chk_w("stop_data", dac_tdata, '0);
    chk_v("stop_state", 32'(state_o), 2);
    chk_v("rep_count", 32'(exp_q.size()), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_v("stop_armed_ignored", 32'(state_o), 2);
    repeat (4) tick();

    // 11-beat frame overflows an 8-word store.
    do_load_start();
    send_frame(11, 100, trc);
    chk_v("tready_cycles11", 32'(trc), 11);
    check_armed();
    play_single();
    do_load_start();

    // Explicit 3-beat frame at 50% valid duty, then random frames.
    send_frame(3, 50, trc);
    check_armed();
    play_single();
    for (int n = 0; n < 6; n++) begin
      do_load_start();
      send_frame($urandom_range(1, 11), 50, trc);
      check_armed();
      play_single();
    end

    // load_start while looping aborts playback and starts a fresh capture.
    do_load_start();
    send_frame(4, 100, trc);
    check_armed();
    for (int i = 0; i < 40; i++) exp_q.push_back(ref_mem[i % ref_loaded]);
    repeat_en = 1'b1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (8) tick();
    chk_v("abort_pre_vld", 32'(dac_tvalid), 1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    exp_q.delete();
    chk_v("abort_vld", 32'(dac_tvalid), 0);
    chk_v("abort_state", 32'(state_o), 1);
    chk_v("abort_loaded", 32'(loaded_words), 0);
    send_frame(3, 100, trc);
    check_armed();
    play_single();

    // Reset mid-LOAD.
    do_load_start();
    s_if.tdata = '1;
    s_if.tvalid = 1'b1;
    tick();
    tick();
    s_if.tvalid = 1'b0;
    pulse_reset();
    tick();

    // Reset mid-RUN after an overflowing frame.
    do_load_start();
    send_frame(9, 100, trc);
    check_armed();
    for (int i = 0; i < 40; i++) exp_q.push_back(ref_mem[i % ref_loaded]);
    repeat_en = 1'b1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat_en = 1'b0;
    repeat (6) tick();
    chk_v("prerst_vld", 32'(dac_tvalid), 1);
    pulse_reset();

    // Trigger before any load_start is ignored.
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int t = 0; t < 6; t++) begin
      chk_v("idle_trig_state", 32'(state_o), 0);
      chk_v("idle_trig_vld", 32'(dac_tvalid), 0);
      tick();
    end

    begin
      int g;
      g = 0;
      while (exp_q.size() > 0 && g < 50) begin
        tick();
        g++;
      end
    end
    chk_v("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
